gate_scheduler: RTL and testbench

GATE_SCHEDULER -- requirements
Module: gate_scheduler

---
 rtl/gate_scheduler.sv | 151 +++++++++++++++
 tb/tb_gate_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_scheduler.sv
// rtl/gate_scheduler.sv - sequences a stored gate program onto a gate-engine issue handshake
module gate_scheduler #(
  parameter int N_QUBITS   = 4,
  parameter int PROG_DEPTH = 64,
  parameter int CNT_W      = 32,
  localparam int QW = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1,
  localparam int AW = $clog2(PROG_DEPTH),
  localparam int DW = 4 + 2 * QW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [DW-1:0]    prog_data,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  input  logic             abort,
  output logic             gate_valid,
  output logic [3:0]       gate_op,
  output logic [QW-1:0]    gate_tgt,
  output logic [QW-1:0]    gate_ctl,
  input  logic             gate_ready,
  input  logic             gate_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [AW:0]      gate_count
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, FIN, ERR} state_e;

  localparam logic [AW:0] DEPTH = (AW + 1)'(PROG_DEPTH);
  localparam logic [QW:0] NQ    = (QW + 1)'(N_QUBITS);

  state_e           state_q;
  logic             busy_q, done_q, err_q, valid_q;
  logic [3:0]       op_q;
  logic [QW-1:0]    tgt_q, ctl_q;
  logic [CNT_W-1:0] cyc_q;
  logic [AW:0]      gcnt_q, len_q;
  logic [AW-1:0]    idx_q;
  logic [DW-1:0]    mem [PROG_DEPTH];
  logic [DW-1:0]    rd_q;

  logic [3:0]    rd_op;
  logic [QW-1:0] rd_ctl, rd_tgt;
  logic          rd_bad, last_gate;
  logic [AW:0]   len_d;

  assign rd_op     = rd_q[DW-1 -: 4];
  assign rd_ctl    = rd_q[2*QW-1 -: QW];
  assign rd_tgt    = rd_q[QW-1:0];
  assign rd_bad    = ({1'b0, rd_tgt} >= NQ) ||
                     (rd_op[3] && (({1'b0, rd_ctl} >= NQ) || (rd_ctl == rd_tgt)));
  assign len_d     = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign last_gate = ({1'b0, idx_q} == len_q - 1'b1);

  // Program storage is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) mem[prog_addr] <= prog_data;
    if (state_q == FETCH) rd_q <= mem[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      tgt_q   <= '0;
      ctl_q   <= '0;
      cyc_q   <= '0;
      gcnt_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (busy_q && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (busy_q && abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
        op_q    <= '0;
        tgt_q   <= '0;
        ctl_q   <= '0;
        if (state_q == EXEC && gate_done) gcnt_q <= gcnt_q + 1'b1;
      end else begin
        case (state_q)
          IDLE, FIN, ERR: if (start) begin
            cyc_q  <= '0;
            gcnt_q <= '0;
            err_q  <= 1'b0;
            len_q  <= len_d;
            idx_q  <= '0;
            if (len_d == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          FETCH: state_q <= ISSUE;
          // First ISSUE cycle validates the fetched entry; valid_q marks the offer phase.
          ISSUE: if (!valid_q) begin
            if (rd_bad) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              op_q    <= rd_op;
              tgt_q   <= rd_tgt;
              ctl_q   <= rd_ctl;
            end
          end else if (gate_ready) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            tgt_q   <= '0;
            ctl_q   <= '0;
            state_q <= EXEC;
          end
          EXEC: if (gate_done) begin
            gcnt_q <= gcnt_q + 1'b1;
            if (last_gate) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gate_valid  = valid_q;
  assign gate_op     = op_q;
  assign gate_tgt    = tgt_q;
  assign gate_ctl    = ctl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cycle_count = cyc_q;
  assign gate_count  = gcnt_q;
endmodule

// File: tb/tb_gate_scheduler.sv
// tb/tb_gate_scheduler.sv - directed self-checking bench for gate_scheduler
module tb_gate_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [6:0]  prog_len;
  logic        start, abort;
  logic        gate_valid;
  logic [3:0]  gate_op;
  logic [1:0]  gate_tgt, gate_ctl;
  logic        gate_ready, gate_done;
  logic        busy, done, err;
  logic [31:0] cycle_count;
  logic [6:0]  gate_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ops[$];
  int         max_vrun;
  bit         changed;
  bit         timed_out;
  logic [7:0] exp_prog [4] = '{8'h10, 8'h21, 8'h33, 8'h86};

  always #5 clk = ~clk;

  gate_scheduler dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .gate_valid(gate_valid), .gate_op(gate_op), .gate_tgt(gate_tgt), .gate_ctl(gate_ctl),
    .gate_ready(gate_ready), .gate_done(gate_done), .busy(busy), .done(done), .err(err),
    .cycle_count(cycle_count), .gate_count(gate_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_prog(input logic [5:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reactive gate engine: records each issued gate, stalls ready, pulses gate_done one cycle after handshake.
  task automatic run_engine(input int stall, input int abort_after, input int max_cycles);
    bit prev_valid = 1'b0;
    bit hs_pending = 1'b0;
    int hs_num = 0;
    int vrun = 0;
    logic [7:0] first = '0;
    ops.delete(); max_vrun = 0; changed = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (done || err || !busy) begin
        timed_out = 1'b0;
        break;
      end
      abort = 1'b0;
      gate_done = hs_pending;
      if (hs_pending) begin
        hs_num++;
        if (hs_num == abort_after) abort = 1'b1;
      end
      hs_pending = 1'b0;
      if (gate_valid) begin
        if (!prev_valid) begin
          first = {gate_op, gate_ctl, gate_tgt};
          ops.push_back(first);
          vrun = 0;
        end else if ({gate_op, gate_ctl, gate_tgt} != first) changed = 1'b1;
        vrun++;
        if (vrun > max_vrun) max_vrun = vrun;
        gate_ready = (vrun > stall);
        if (gate_ready) hs_pending = 1'b1;
      end else begin
        gate_ready = (stall == 0);
      end
      prev_valid = gate_valid;
      tick();
    end
    gate_done = 1'b0; abort = 1'b0; gate_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if ({busy, done, err, gate_valid} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, gate_valid}); end
    n_cmp++; if ({gate_op, gate_tgt, gate_ctl} !== 8'h0) begin n_err++; $display("FAIL reset_fields: got %h want 00", {gate_op, gate_tgt, gate_ctl}); end
    n_cmp++; if (cycle_count !== 32'd0 || gate_count !== 7'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", cycle_count, gate_count); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_gates();
    for (int i = 0; i < 4; i++) write_prog(6'(i), exp_prog[i]);
    do_start(7'd3);
    n_cmp++; if (busy !== 1'b1 || cycle_count !== 32'd0) begin n_err++; $display("FAIL run3_launch: busy %b cyc %0d want 1 0", busy, cycle_count); end
    run_engine(0, 0, 100);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL run3_timeout: got %b want 0", timed_out); end
    n_cmp++; if (ops.size() !== 3) begin n_err++; $display("FAIL run3_n_issued: got %0d want 3", ops.size()); end
    for (int i = 0; i < 3 && i < ops.size(); i++) begin
      n_cmp++; if (ops[i] !== exp_prog[i]) begin n_err++; $display("FAIL run3_gate%0d: got %h want %h", i, ops[i], exp_prog[i]); end
    end
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL run3_status: got d%b e%b b%b want 1 0 0", done, err, busy); end
    n_cmp++; if (gate_count !== 7'd3) begin n_err++; $display("FAIL run3_gate_count: got %0d want 3", gate_count); end
    n_cmp++; if (cycle_count !== 32'd12) begin n_err++; $display("FAIL run3_cycle_count: got %0d want 12", cycle_count); end
    gate_done = 1'b1; tick(); gate_done = 1'b0;
    tick(); tick();
    n_cmp++; if (done !== 1'b1 || gate_count !== 7'd3 || cycle_count !== 32'd12) begin n_err++; $display("FAIL fin_sticky: d%b g%0d c%0d want 1 3 12", done, gate_count, cycle_count); end
  endtask

  task automatic test_zero_len();
    do_start(7'd0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || gate_valid !== 1'b0) begin n_err++; $display("FAIL zero_status: d%b b%b v%b want 1 0 0", done, busy, gate_valid); end
    n_cmp++; if (cycle_count !== 32'd0 || gate_count !== 7'd0) begin n_err++; $display("FAIL zero_counts: c%0d g%0d want 0 0", cycle_count, gate_count); end
  endtask

  task automatic test_bad_entry();
    write_prog(6'd1, 8'h8A);
    do_start(7'd3);
    run_engine(0, 0, 100);
    n_cmp++; if (ops.size() !== 1) begin n_err++; $display("FAIL bad_n_issued: got %0d want 1", ops.size()); end
    n_cmp++; if (ops.size() > 0 && ops[0] !== 8'h10) begin n_err++; $display("FAIL bad_gate0: got %h want 10", ops[0]); end
    n_cmp++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bad_status: e%b d%b b%b want 1 0 0", err, done, busy); end
    n_cmp++; if (gate_count !== 7'd1 || cycle_count !== 32'd6) begin n_err++; $display("FAIL bad_counts: g%0d c%0d want 1 6", gate_count, cycle_count); end
    write_prog(6'd1, exp_prog[1]);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_stall();
    do_start(7'd1);
    run_engine(5, 0, 100);
    n_cmp++; if (max_vrun !== 6 || changed !== 1'b0) begin n_err++; $display("FAIL stall_hold: run %0d changed %b want 6 0", max_vrun, changed); end
    n_cmp++; if (done !== 1'b1 || cycle_count !== 32'd9) begin n_err++; $display("FAIL stall_count: d%b c%0d want 1 9", done, cycle_count); end
  endtask

  task automatic test_abort();
    do_start(7'd4);
    run_engine(0, 2, 100);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || gate_valid !== 1'b0) begin n_err++; $display("FAIL abort_status: b%b d%b e%b v%b want 0000", busy, done, err, gate_valid); end
    n_cmp++; if (gate_count !== 7'd2) begin n_err++; $display("FAIL abort_gate_count: got %0d want 2", gate_count); end
    tick(); tick(); tick();
    n_cmp++; if (cycle_count !== 32'd8 || gate_count !== 7'd2) begin n_err++; $display("FAIL abort_hold: c%0d g%0d want 8 2", cycle_count, gate_count); end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_idle_ignored: b%b d%b want 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    prog_len = 7'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b1 || cycle_count !== 32'd0 || gate_count !== 7'd0) begin n_err++; $display("FAIL start_over_abort: b%b c%0d g%0d want 1 0 0", busy, cycle_count, gate_count); end
    prog_we = 1'b1; prog_addr = 6'd3; prog_data = 8'hFF;
    tick();
    prog_we = 1'b0;
    run_engine(0, 0, 100);
    n_cmp++; if (ops.size() !== 4) begin n_err++; $display("FAIL rerun_n_issued: got %0d want 4", ops.size()); end
    for (int i = 0; i < 4 && i < ops.size(); i++) begin
      n_cmp++; if (ops[i] !== exp_prog[i]) begin n_err++; $display("FAIL rerun_gate%0d: got %h want %h", i, ops[i], exp_prog[i]); end
    end
    n_cmp++; if (done !== 1'b1 || gate_count !== 7'd4 || cycle_count !== 32'd16) begin n_err++; $display("FAIL rerun_end: d%b g%0d c%0d want 1 4 16", done, gate_count, cycle_count); end
  endtask

  task automatic test_reset_mid_issue();
    do_start(7'd3);
    tick(); tick();
    n_cmp++; if (gate_valid !== 1'b1 || {gate_op, gate_ctl, gate_tgt} !== 8'h10) begin n_err++; $display("FAIL pre_reset_issue: v%b f%h want 1 10", gate_valid, {gate_op, gate_ctl, gate_tgt}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, err, gate_valid, gate_op, gate_tgt, gate_ctl} !== 12'h0) begin n_err++; $display("FAIL async_reset_out: got %h want 000", {busy, done, err, gate_valid, gate_op, gate_tgt, gate_ctl}); end
    n_cmp++; if (cycle_count !== 32'd0 || gate_count !== 7'd0) begin n_err++; $display("FAIL async_reset_cnt: c%0d g%0d want 0 0", cycle_count, gate_count); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: b%b d%b e%b want 0 0 0", busy, done, err); end
    do_start(7'd3);
    run_engine(0, 0, 100);
    n_cmp++; if (ops.size() !== 3) begin n_err++; $display("FAIL retained_n_issued: got %0d want 3", ops.size()); end
    for (int i = 0; i < 3 && i < ops.size(); i++) begin
      n_cmp++; if (ops[i] !== exp_prog[i]) begin n_err++; $display("FAIL retained_gate%0d: got %h want %h", i, ops[i], exp_prog[i]); end
    end
    n_cmp++; if (done !== 1'b1 || gate_count !== 7'd3 || cycle_count !== 32'd12) begin n_err++; $display("FAIL retained_end: d%b g%0d c%0d want 1 3 12", done, gate_count, cycle_count); end
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; gate_ready = 1'b0; gate_done = 1'b0;
    test_reset();
    test_three_gates();
    test_zero_len();
    test_bad_entry();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
